// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the RAM port arbiter.
// The defaults here describe the standard three-reader build.
package ram_arb_pkg;

  localparam int NR     = 3;
  localparam int N      = NR + 1;
  localparam int PW     = $clog2(N);
  localparam int WR_IDX = NR;

  typedef struct packed {
    logic          vld;
    logic [PW-1:0] idx;
  } tag_t;

  // Wrap with an explicit compare so non-power-of-two requester counts work.
  function automatic int wrap_inc(input int p, input int n);
    return (p == n - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arbiter.sv
// Round-robin picker: the first requester at or after ptr (mod N) wins.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  always_comb begin
    int cand;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = int'(ptr);
    for (int k = 0; k < N; k++) begin
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = PW'(cand);
      end
      cand = wrap_inc(cand, N);
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between NR readers and one writer, one access per cycle.
// Command is registered; read data returns through a tag pipeline to the issuing reader.
module ram_port_arbiter #(
  parameter int NR     = 3,
  parameter int AW     = 28,
  parameter int DW     = 128,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NR-1:0]      rd_req,
  input  logic [NR*AW-1:0]   rd_addr,
  output logic [NR-1:0]      rd_gnt,
  output logic [NR-1:0]      rd_rvalid,
  output logic [DW-1:0]      rd_rdata,
  input  logic               wr_req,
  input  logic [AW-1:0]      wr_addr,
  input  logic [DW-1:0]      wr_data,
  input  logic [DW/8-1:0]    wr_strb,
  output logic               wr_gnt,
  output logic               mem_ren,
  output logic               mem_wen,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  output logic [DW/8-1:0]    mem_strb,
  input  logic [DW-1:0]      mem_rdata
);
  import ram_arb_pkg::*;

  localparam int NQ = NR + 1;
  localparam int QW = $clog2(NQ);

  typedef struct packed {
    logic          vld;
    logic [QW-1:0] idx;
  } rd_tag_t;

  logic [NQ-1:0] req_vec;
  logic [NQ-1:0] gnt_vec;
  logic [QW-1:0] ptr;
  logic [QW-1:0] gnt_idx;
  logic          gnt_any;
  logic          gnt_is_wr;
  logic [AW-1:0] rd_sel_addr;
  rd_tag_t       tag_pipe [RD_LAT+1];

  // Masking requests in reset keeps grants low without touching the arbiter.
  assign req_vec = rstn ? {wr_req, rd_req} : '0;

  rr_arbiter #(.N(NQ), .PW(QW)) u_rr (
    .req (req_vec),
    .ptr (ptr),
    .gnt (gnt_vec),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign rd_gnt    = gnt_vec[NR-1:0];
  assign wr_gnt    = gnt_vec[NR];
  assign gnt_is_wr = gnt_vec[NR];
  assign rd_rdata  = mem_rdata;

  always_comb begin
    rd_sel_addr = rd_addr[0 +: AW];
    for (int i = 0; i < NR; i++) begin
      if (gnt_idx == QW'(i)) rd_sel_addr = rd_addr[i*AW +: AW];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= QW'(wrap_inc(int'(gnt_idx), NQ));
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem_ren   <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_strb  <= '0;
    end else begin
      mem_ren <= gnt_any && !gnt_is_wr;
      mem_wen <= gnt_any && gnt_is_wr;
      if (gnt_any) begin
        mem_addr <= gnt_is_wr ? wr_addr : rd_sel_addr;
      end
      if (gnt_any && gnt_is_wr) begin
        mem_wdata <= wr_data;
        mem_strb  <= wr_strb;
      end
    end
  end

  // Stage 0 lines up with mem_ren; stage RD_LAT lines up with valid mem_rdata.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int s = 0; s <= RD_LAT; s++) tag_pipe[s] <= '0;
    end else begin
      tag_pipe[0].vld <= gnt_any && !gnt_is_wr;
      tag_pipe[0].idx <= gnt_idx;
      for (int s = 1; s <= RD_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  always_comb begin
    rd_rvalid = '0;
    for (int i = 0; i < NR; i++) begin
      if (tag_pipe[RD_LAT].vld && tag_pipe[RD_LAT].idx == QW'(i)) rd_rvalid[i] = 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed steps plus random traffic checked against
// a cycle-level reference of the arbitration rules and a golden memory image.
module tb_ram_port_arbiter;
  localparam int NR     = 3;
  localparam int AW     = 28;
  localparam int DW     = 128;
  localparam int RD_LAT = 1;
  localparam int N      = NR + 1;
  localparam int SW     = DW / 8;
  localparam int MW     = 64;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [NR-1:0]   rd_req = '0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR-1:0]   rd_gnt, rd_rvalid;
  logic [DW-1:0]   rd_rdata;
  logic            wr_req = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [DW-1:0]   wr_data = '0;
  logic [SW-1:0]   wr_strb = '0;
  logic            wr_gnt, mem_ren, mem_wen;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [SW-1:0]   mem_strb;
  logic [DW-1:0]   mem_rdata;

  always #5 clk = ~clk;

  ram_port_arbiter #(.NR(NR), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rstn(rstn),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_gnt(wr_gnt),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_strb(mem_strb), .mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 16) return {SW{8'hAA}};
    return {4{32'hA500_0000 | i}};
  endfunction

  // Behavioural single-port RAM with RD_LAT cycles of read latency.
  logic [DW-1:0] ram [MW];
  logic [DW-1:0] rp  [RD_LAT];
  logic          ram_first = 1'b1;
  assign mem_rdata = rp[RD_LAT-1];

  always @(posedge clk) begin
    if (ram_first) begin
      for (int i = 0; i < MW; i++) ram[i] <= init_word(i);
      ram_first <= 1'b0;
    end else if (mem_wen) begin
      for (int b = 0; b < SW; b++)
        if (mem_strb[b]) ram[mem_addr[5:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
    rp[0] <= mem_ren ? ram[mem_addr[5:0]] : '0;
    for (int s = 1; s < RD_LAT; s++) rp[s] <= rp[s-1];
  end

  // Reference model state
  int            tests = 0, fails = 0, cyc = 0;
  int            m_ptr = 0;
  logic          e_ren = 1'b0, e_wen = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0;
  logic [SW-1:0] e_strb = '0;
  logic [DW-1:0] gm [MW];
  logic          sv [8];
  int            si [8];
  logic [DW-1:0] sd [8];
  int            g_last = -1, obs_g = -1;
  int            dir_cyc = -1;
  logic [DW-1:0] dir_exp = '0;
  int            seq [$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    int g, c, a, slot, s2;
    logic [N-1:0]  rq;
    logic [NR-1:0] erg;
    logic [NR-1:0] erv;
    @(negedge clk);
    rq = {wr_req, rd_req};
    g  = -1;
    if (rstn)
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (g < 0 && rq[c]) g = c;
      end
    erg = '0;
    if (g >= 0 && g < NR) erg[g] = 1'b1;
    slot = cyc % 8;
    erv = '0;
    if (sv[slot]) erv[si[slot]] = 1'b1;
    obs_g = -1;
    for (int i = 0; i < NR; i++) if (rd_gnt[i]) obs_g = i;
    if (wr_gnt) obs_g = NR;

    chk("rd_gnt",    DW'(rd_gnt),    DW'(erg));
    chk("wr_gnt",    DW'(wr_gnt),    DW'(g == NR));
    chk("mem_ren",   DW'(mem_ren),   DW'(e_ren));
    chk("mem_wen",   DW'(mem_wen),   DW'(e_wen));
    chk("mem_addr",  DW'(mem_addr),  DW'(e_addr));
    chk("mem_wdata", mem_wdata,      e_wdata);
    chk("mem_strb",  DW'(mem_strb),  DW'(e_strb));
    chk("rd_rvalid", DW'(rd_rvalid), DW'(erv));
    if (sv[slot]) chk("rd_rdata", rd_rdata, sd[slot]);
    if (cyc == dir_cyc) chk("dir_rdata", rd_rdata, dir_exp);

    if (!rstn) begin
      m_ptr = 0; e_ren = 1'b0; e_wen = 1'b0;
      e_addr = '0; e_wdata = '0; e_strb = '0;
      for (int s = 0; s < 8; s++) sv[s] = 1'b0;
    end else begin
      sv[slot] = 1'b0;
      e_ren = 1'b0; e_wen = 1'b0;
      if (g >= 0) begin
        m_ptr = (g + 1) % N;
        if (g < NR) begin
          e_ren  = 1'b1;
          e_addr = rd_addr[g*AW +: AW];
          a      = int'(e_addr[5:0]);
          s2     = (cyc + 1 + RD_LAT) % 8;
          sv[s2] = 1'b1; si[s2] = g; sd[s2] = gm[a];
        end else begin
          e_wen = 1'b1; e_addr = wr_addr; e_wdata = wr_data; e_strb = wr_strb;
          a = int'(wr_addr[5:0]);
          for (int b = 0; b < SW; b++) if (wr_strb[b]) gm[a][b*8 +: 8] = wr_data[b*8 +: 8];
        end
      end
    end
    g_last = g;
    cyc++;
    @(posedge clk);
    #1;
    if (g_last >= 0 && g_last < NR) rd_req[g_last] = 1'b0;
    if (g_last == NR) wr_req = 1'b0;
  endtask

  task automatic rd_issue(input int i, input int addr);
    rd_req[i] = 1'b1;
    rd_addr[i*AW +: AW] = AW'(addr);
  endtask

  task automatic wr_issue(input int addr, input logic [DW-1:0] d, input logic [SW-1:0] s);
    wr_req = 1'b1; wr_addr = AW'(addr); wr_data = d; wr_strb = s;
  endtask

  task automatic drain();
    int n = 0;
    while ((rd_req != '0 || wr_req) && n < 2 * N) begin
      tick();
      n++;
    end
    tests++;
    assert (rd_req == '0 && !wr_req) else begin
      fails++;
      $error("FAIL drain_timeout observed=%b/%b expected=all granted", rd_req, wr_req);
    end
  endtask

  initial begin
    logic [DW-1:0] allf;
    int exp_seq [8];
    allf = '1;
    for (int i = 0; i < MW; i++) gm[i] = init_word(i);
    for (int s = 0; s < 8; s++) begin sv[s] = 1'b0; si[s] = 0; sd[s] = '0; end

    // Reset values
    tick(); tick();
    rstn = 1'b1;
    tick();

    // All four requesting continuously from reset: 0,1,2,W,0,1,2,W
    exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NR; i++) if (!rd_req[i]) rd_issue(i, 8 + i);
      if (!wr_req) wr_issue(48 + k, {4{$urandom}}, '1);
      tick();
      chk("rr_order", DW'(obs_g), DW'(exp_seq[k]));
    end
    drain();

    // Single reader from 0x10
    rd_issue(1, 'h10);
    dir_cyc = cyc + 1 + RD_LAT; dir_exp = {SW{8'hAA}};
    tick();
    chk("single_gnt", DW'(obs_g), DW'(1));
    repeat (RD_LAT + 2) tick();

    // Write then read, full strobes, then byte-0-only over all-ones
    wr_issue('h20, DW'(32'h1234), '1);
    drain();
    rd_issue(0, 'h20);
    dir_cyc = cyc + 1 + RD_LAT; dir_exp = DW'(32'h1234);
    repeat (RD_LAT + 2) tick();
    wr_issue('h20, allf, '1);
    drain();
    wr_issue('h20, DW'(32'h1234), SW'(1));
    drain();
    rd_issue(0, 'h20);
    dir_cyc = cyc + 1 + RD_LAT; dir_exp = {allf[DW-1:8], 8'h34};
    repeat (RD_LAT + 2) tick();

    // Pointer skip: put pointer at 2, then reader 0 and writer contend
    rd_issue(1, 3);
    tick();
    rd_issue(0, 4);
    wr_issue(5, {4{32'h5A5A_0001}}, '1);
    tick();
    chk("skip_first", DW'(obs_g), DW'(NR));
    tick();
    chk("skip_second", DW'(obs_g), DW'(0));
    rd_issue(0, 6); rd_issue(1, 7);
    tick();
    chk("ptr_at_1", DW'(obs_g), DW'(1));
    drain();
    repeat (RD_LAT + 2) tick();

    // Reset mid-flight
    rd_issue(0, 3); rd_issue(2, 5);
    tick(); tick();
    rstn = 1'b0;
    rd_issue(1, 9);
    tick(); tick();
    rd_req = '0; wr_req = 1'b0;
    rstn = 1'b1;
    rd_issue(1, 10); rd_issue(2, 11);
    tick();
    chk("post_reset_gnt", DW'(obs_g), DW'(1));
    drain();
    repeat (RD_LAT + 2) tick();

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NR; i++)
        if (!rd_req[i] && $urandom_range(0, 1) == 1) rd_issue(i, int'($urandom_range(0, 31)));
      if (!wr_req && $urandom_range(0, 2) == 0)
        wr_issue(int'($urandom_range(0, 31)), {$urandom, $urandom, $urandom, $urandom},
                 ($urandom_range(0, 1) == 1) ? '1 : SW'($urandom));
      tick();
    end
    drain();
    repeat (RD_LAT + 2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
